// File: rtl/bus_capture_sync.sv
// bus_capture_sync
//   Destination-domain capture stage behind the bit synchronizer. Detects the
//   rising edge of the synchronized enable, qualifies it with a glitch filter,
//   samples the quasi-static source bus, and holds the word behind a
//   valid/ready handshake. Edges arriving while a word is still held are
//   counted as drops.
//
// Ports
//   clk         destination-domain clock
//   rst         synchronous active-high reset
//   sync_en     enable level, already synchronized to clk
//   async_data  source-domain bus, stable while the source enable is high
//   out_ready   consumer accepts out_data this cycle
//   ovf_clr     single-cycle clear of overflow / drop_count
//   out_valid   out_data holds a captured word
//   out_data    captured word (retained between events)
//   overflow    sticky: at least one event dropped
//   drop_count  dropped-event count, saturating at 255
module bus_capture_sync #(
   parameter int BUS_WIDTH     = 8,
   parameter int FILTER_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sync_en,
   input  logic [BUS_WIDTH-1:0] async_data,
   input  logic                 out_ready,
   input  logic                 ovf_clr,
   output logic                 out_valid,
   output logic [BUS_WIDTH-1:0] out_data,
   output logic                 overflow,
   output logic [7:0]           drop_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      QUAL  = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           qcnt_q, qcnt_d;
   logic                 sync_en_q, sync_en_d;
   logic [BUS_WIDTH-1:0] out_data_q, out_data_d;
   logic                 overflow_q, overflow_d;
   logic [7:0]           drop_count_q, drop_count_d;

   logic                 rise;
   logic                 drop;
   logic [7:0]           cnt_base;

   assign rise = sync_en & ~sync_en_q;
   // Only VALID can see a fresh edge: QUAL implies sync_en has been high
   // since the edge that started qualification.
   assign drop = rise & (state_q == VALID);

   always_comb begin
      state_d      = state_q;
      qcnt_d       = qcnt_q;
      sync_en_d    = sync_en;
      out_data_d   = out_data_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      cnt_base     = drop_count_q;

      unique case (state_q)
         IDLE: begin
            if (rise) begin
               if (FILTER_CYCLES == 1) begin
                  out_data_d = async_data;
                  state_d    = VALID;
               end else begin
                  qcnt_d  = 4'd1;
                  state_d = QUAL;
               end
            end
         end
         QUAL: begin
            if (!sync_en) begin
               qcnt_d  = 4'd0;
               state_d = IDLE;
            end else if (({1'b0, qcnt_q} + 5'd1) == 5'(FILTER_CYCLES)) begin
               out_data_d = async_data;
               qcnt_d     = 4'd0;
               state_d    = VALID;
            end else begin
               qcnt_d = qcnt_q + 4'd1;
            end
         end
         VALID: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A drop coincident with a clear counts from zero, so it still shows.
      if (ovf_clr) begin
         overflow_d   = 1'b0;
         drop_count_d = 8'd0;
         cnt_base     = 8'd0;
      end
      if (drop) begin
         overflow_d   = 1'b1;
         drop_count_d = (cnt_base == 8'hFF) ? 8'hFF : cnt_base + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         qcnt_q       <= 4'd0;
         sync_en_q    <= 1'b0;
         out_data_q   <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         qcnt_q       <= qcnt_d;
         sync_en_q    <= sync_en_d;
         out_data_q   <= out_data_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign out_valid  = (state_q == VALID);
   assign out_data   = out_data_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule
